// File: rtl/fifo_0r1w_pkg.sv
// Shared sizing helpers for the first-word-fall-through FIFO.
// Keeps pointer/count width rules in one place for the top and the pointer module.
package fifo_0r1w_pkg;

  // A one-entry FIFO still needs a 1-bit pointer so the port is never zero-width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_0r1w_ptr.sv
// Wrap-around pointer register: counts 0..DEPTH-1 and returns to 0.
// Works for any DEPTH, including non-powers of two.
module fifo_0r1w_ptr
  import fifo_0r1w_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_advance,
  output logic [ptr_width(DEPTH)-1:0]  o_ptr
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_0r1w.sv
// First-word-fall-through FIFO: head word is combinational from storage, writes land in one cycle.
// Optional FIFO_0R1W_ASSERTIONS_EN compiles overflow/underflow/consistency assertions.
module fifo_0r1w
  import fifo_0r1w_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  output logic              o_full,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_empty,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push_ok;
  logic              pop_ok;

  // Flags come from pre-edge state, so a push on a full FIFO is dropped even with a pop.
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == DEPTH_C);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  fifo_0r1w_ptr #(.DEPTH(DEPTH)) u_wptr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_advance (push_ok),
    .o_ptr     (wptr)
  );

  fifo_0r1w_ptr #(.DEPTH(DEPTH)) u_rptr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_advance (pop_ok),
    .o_ptr     (rptr)
  );

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; o_rdata is only meaningful while ~o_empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wptr] <= i_wdata;
    end
  end

  assign o_rdata = mem[rptr];

`ifdef FIFO_0R1W_ASSERTIONS_EN
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && o_empty));
  a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= DEPTH_C);
  a_flags_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_full && o_empty));
`else
`endif

endmodule

// File: tb/tb_fifo_0r1w.sv
// Directed self-checking bench for fifo_0r1w at DWIDTH=32, DEPTH=3.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next rising edge.
module tb_fifo_0r1w;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 3;

  logic              clk;
  logic              rst_n;
  logic              push;
  logic              pop;
  logic [DWIDTH-1:0] wdata;
  logic              full;
  logic              empty;
  logic [DWIDTH-1:0] rdata;

  int vectors;
  int miscompares;

  fifo_0r1w #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (push),
    .o_full  (full),
    .i_wdata (wdata),
    .i_pop   (pop),
    .o_empty (empty),
    .o_rdata (rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: apply one cycle of request, then go idle
  task automatic drive(input logic p, input logic [DWIDTH-1:0] d, input logic q);
    push  = p;
    wdata = d;
    pop   = q;
    step();
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wdata = '0;
    step();
    step();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL reset_flags: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL reset_release: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
  endtask

  task automatic test_first_push();
    drive(1'b1, 32'hCAFEBABE, 1'b0);
    vectors++;
    if (empty !== 1'b0 || rdata !== 32'hCAFEBABE) begin
      $display("FAIL first_push: empty=%b rdata=%h, need empty=0 rdata=cafebabe", empty, rdata);
      miscompares++;
    end
  endtask

  task automatic test_push_pop();
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    vectors++;
    if (empty !== 1'b0 || full !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      $display("FAIL push_pop: empty=%b full=%b rdata=%h, need 0 0 deadbeef", empty, full, rdata);
      miscompares++;
    end
    drive(1'b1, 32'hA5A5A5A5, 1'b1);
    vectors++;
    if (empty !== 1'b0 || rdata !== 32'hA5A5A5A5) begin
      $display("FAIL push_pop_2: empty=%b rdata=%h, need empty=0 rdata=a5a5a5a5", empty, rdata);
      miscompares++;
    end
    drive(1'b0, '0, 1'b1);
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL push_pop_drain: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DWIDTH-1:0] words [3];
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], (i != 0));
      vectors++;
      if (empty !== 1'b0 || rdata !== words[i]) begin
        $display("FAIL back_to_back[%0d]: empty=%b rdata=%h, need empty=0 rdata=%h",
                 i, empty, rdata, words[i]);
        miscompares++;
      end
    end
    drive(1'b0, '0, 1'b1);
    vectors++;
    if (empty !== 1'b1) begin
      $display("FAIL back_to_back_end: empty=%b, need 1", empty);
      miscompares++;
    end
  endtask

  task automatic test_full();
    logic [DWIDTH-1:0] words [3];
    words[0] = 32'h0000A001;
    words[1] = 32'h0000B002;
    words[2] = 32'h0000C003;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0);
      vectors++;
      if (full !== (i == 2) || empty !== 1'b0 || rdata !== words[0]) begin
        $display("FAIL fill[%0d]: full=%b empty=%b rdata=%h, need full=%b empty=0 rdata=%h",
                 i, full, empty, rdata, (i == 2), words[0]);
        miscompares++;
      end
    end
    drive(1'b1, 32'hBAD00004, 1'b0);
    vectors++;
    if (full !== 1'b1 || rdata !== words[0]) begin
      $display("FAIL push_when_full: full=%b rdata=%h, need full=1 rdata=%h", full, rdata, words[0]);
      miscompares++;
    end
    // push is dropped, pop is accepted
    drive(1'b1, 32'hBAD00005, 1'b1);
    vectors++;
    if (full !== 1'b0 || empty !== 1'b0 || rdata !== words[1]) begin
      $display("FAIL push_pop_when_full: full=%b empty=%b rdata=%h, need 0 0 %h",
               full, empty, rdata, words[1]);
      miscompares++;
    end
    drive(1'b0, '0, 1'b1);
    vectors++;
    if (empty !== 1'b0 || rdata !== words[2]) begin
      $display("FAIL drain_3rd: empty=%b rdata=%h, need empty=0 rdata=%h", empty, rdata, words[2]);
      miscompares++;
    end
    drive(1'b0, '0, 1'b1);
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL drain_end: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
  endtask

  task automatic test_pop_empty();
    drive(1'b0, '0, 1'b1);
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL pop_empty: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
    drive(1'b1, 32'h5EED0001, 1'b1);
    vectors++;
    if (empty !== 1'b0 || rdata !== 32'h5EED0001) begin
      $display("FAIL push_pop_empty: empty=%b rdata=%h, need empty=0 rdata=5eed0001", empty, rdata);
      miscompares++;
    end
    drive(1'b1, 32'h5EED0002, 1'b0);
    vectors++;
    if (empty !== 1'b0 || full !== 1'b0 || rdata !== 32'h5EED0001) begin
      $display("FAIL second_entry: empty=%b full=%b rdata=%h, need 0 0 5eed0001", empty, full, rdata);
      miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL async_reset: empty=%b full=%b, need empty=1 full=0", empty, full);
      miscompares++;
    end
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 32'h0BADF00D, 1'b0);
    vectors++;
    if (empty !== 1'b0 || full !== 1'b0 || rdata !== 32'h0BADF00D) begin
      $display("FAIL post_reset_push: empty=%b full=%b rdata=%h, need 0 0 0badf00d",
               empty, full, rdata);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    wdata       = '0;
    test_reset();
    test_first_push();
    test_push_pop();
    test_back_to_back();
    test_full();
    test_pop_empty();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
